button_events: RTL and testbench

BUTTON_EVENTS -- requirements
Module: button_events

---
 rtl/button_events_pkg.sv | 17 +
 rtl/button_events_hold_timer.sv | 40 ++++
 rtl/button_events.sv | 116 +++++++++++
 tb/tb_button_events.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/button_events_pkg.sv
// Shared button definitions: FSM state encodings and a timer width helper
// used by the button blocks.
package button_events_pkg;

    typedef enum logic [1:0] {
        LOCKOUT   = 2'd0,
        IDLE      = 2'd1,
        PRESSED   = 2'd2,
        LONG_HELD = 2'd3
    } btn_state_e;

    // A one-cycle threshold would still need a one-bit counter.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/button_events_hold_timer.sv
// Hold timer: counts enabled cycles after a clear, saturating at LONG_CYCLES-1
// and flagging done while it sits at that value.
module hold_timer
    import button_events_pkg::*;
#(
    parameter int LONG_CYCLES = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int TW = timer_width(LONG_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(LONG_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/button_events.sv
// Button event generator: turns a debounced level into press/release/click/
// long-press pulses plus a press counter, with all outputs registered.
module button_events
    import button_events_pkg::*;
#(
    parameter int LONG_CYCLES = 12000000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_in,
    output logic             pressed,
    output logic             press,
    output logic             release_pulse,
    output logic             click,
    output logic             long_press,
    output logic [CNT_W-1:0] count
);

    btn_state_e       state_q, state_d;
    logic             pressed_q, pressed_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             click_q, click_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tmr_clr, tmr_en, tmr_done;

    hold_timer #(
        .LONG_CYCLES(LONG_CYCLES)
    ) u_hold_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .done(tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        count_d   = count_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;

        case (state_q)
            // A button already down at reset must be seen released first.
            LOCKOUT: begin
                if (!sw_in) state_d = IDLE;
            end
            IDLE: begin
                if (sw_in) begin
                    state_d = PRESSED;
                    tmr_clr = 1'b1;
                    press_d = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (sw_in) begin
                    tmr_en = 1'b1;
                    if (tmr_done) begin
                        state_d = LONG_HELD;
                        long_d  = 1'b1;
                    end
                end else begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end
            end
            LONG_HELD: begin
                if (sw_in) begin
                    tmr_en = 1'b1;
                end else begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end
            end
            default: state_d = LOCKOUT;
        endcase

        pressed_d = (state_d == PRESSED) || (state_d == LONG_HELD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOCKOUT;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
            count_q   <= count_d;
        end
    end

    assign pressed       = pressed_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign click         = click_q;
    assign long_press    = long_q;
    assign count         = count_q;

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: event-level reference model checked every cycle,
// plus directed scenarios with hand-computed timing and count expectations.
module tb_button_events;

    localparam int LC = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          sw_in;
    logic          pressed, press, release_pulse, click, long_press;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    button_events #(
        .LONG_CYCLES(LC),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_in        (sw_in),
        .pressed      (pressed),
        .press        (press),
        .release_pulse(release_pulse),
        .click        (click),
        .long_press   (long_press),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: reasons in terms of "button armed", "being held" and
    // the number of held samples since the press, not in FSM states.
    bit model_valid = 0;
    bit armed = 0;
    bit held = 0;
    int hold_len = 0;
    int presses = 0;
    int cyc = 0;
    bit e_press, e_rel, e_click, e_long, e_pressed;

    always @(posedge clk) begin
        cyc++;
        e_press = 0; e_rel = 0; e_click = 0; e_long = 0;
        if (rst) begin
            model_valid = 1;
            armed = 0; held = 0; hold_len = 0; presses = 0;
        end else if (!held) begin
            if (!sw_in) begin
                armed = 1;
            end else if (armed) begin
                held = 1; hold_len = 0; e_press = 1; presses++;
            end
        end else if (sw_in) begin
            if (hold_len < LC) begin
                hold_len++;
                if (hold_len == LC) e_long = 1;
            end
        end else begin
            held = 0; e_rel = 1; e_click = (hold_len < LC);
        end
        e_pressed = held;
    end

    // Event log filled by the compare process for the directed checks.
    int press_cyc, long_cyc, rel_cyc;
    int n_press, n_long, n_rel, n_click, pressed_cnt;

    always @(negedge clk) begin
        if (model_valid) begin
            check("pressed", 32'(pressed), 32'(e_pressed));
            check("press", 32'(press), 32'(e_press));
            check("release", 32'(release_pulse), 32'(e_rel));
            check("click", 32'(click), 32'(e_click));
            check("long_press", 32'(long_press), 32'(e_long));
            check("count", 32'(count), 32'(presses % (1 << CW)));
            if (press === 1'b1) begin
                press_cyc = cyc; n_press++;
                $display("cycle %0d: press count=%0d", cyc, count);
            end
            if (long_press === 1'b1) begin
                long_cyc = cyc; n_long++;
                $display("cycle %0d: long_press", cyc);
            end
            if (release_pulse === 1'b1) begin
                rel_cyc = cyc; n_rel++;
                $display("cycle %0d: release click=%0d", cyc, click);
            end
            if (click === 1'b1) n_click++;
            if (pressed === 1'b1) pressed_cnt++;
        end
    end

    task automatic clear_log();
        press_cyc = 0; long_cyc = 0; rel_cyc = 0;
        n_press = 0; n_long = 0; n_rel = 0; n_click = 0; pressed_cnt = 0;
    endtask

    task automatic cycles(input logic s, input int n);
        repeat (n) begin
            sw_in = s;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(1'b0, 2);
        rst = 1'b0;
        cycles(1'b0, 2);
        clear_log();
    endtask

    int exp_wrap[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    initial begin
        clear_log();
        // Button held through reset stays locked out.
        rst = 1'b1;
        cycles(1'b1, 2);
        check("rst_count", 32'(count), 0);
        check("rst_pressed", 32'(pressed), 0);
        rst = 1'b0;
        cycles(1'b1, 10);
        check("lockout_presses", 32'(n_press), 0);
        check("lockout_pressed", 32'(pressed), 0);
        check("lockout_count", 32'(count), 0);
        cycles(1'b0, 1);
        cycles(1'b1, 1);
        check("unlock_press", 32'(press), 1);
        check("unlock_count", 32'(count), 1);
        cycles(1'b1, 1);
        cycles(1'b0, 2);

        // Short 3-cycle press.
        do_reset();
        cycles(1'b1, 3);
        cycles(1'b0, 3);
        check("short_rel_delay", 32'(rel_cyc - press_cyc), 3);
        check("short_click", 32'(n_click), 1);
        check("short_long", 32'(n_long), 0);
        check("short_count", 32'(count), 1);

        // 20-cycle hold crosses the long threshold.
        do_reset();
        cycles(1'b1, 20);
        cycles(1'b0, 3);
        check("long_delay", 32'(long_cyc - press_cyc), 8);
        check("long_count_pulses", 32'(n_long), 1);
        check("long_rel_delay", 32'(rel_cyc - press_cyc), 20);
        check("long_rel_count", 32'(n_rel), 1);
        check("long_no_click", 32'(n_click), 0);
        check("long_pressed_cycles", 32'(pressed_cnt), 20);

        // Nine short presses wrap the 3-bit counter.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycles(1'b1, 1);
            check("wrap_count", 32'(count), 32'(exp_wrap[i]));
            cycles(1'b0, 1);
        end

        // Reset in the middle of a hold.
        do_reset();
        cycles(1'b1, 6);
        rst = 1'b1;
        cycles(1'b1, 1);
        rst = 1'b0;
        cycles(1'b1, 12);
        check("midrst_press", 32'(n_press), 1);
        check("midrst_long", 32'(n_long), 0);
        check("midrst_rel", 32'(n_rel), 0);
        check("midrst_click", 32'(n_click), 0);
        check("midrst_pressed", 32'(pressed), 0);
        cycles(1'b0, 1);
        cycles(1'b1, 1);
        check("midrst_repress", 32'(press), 1);
        cycles(1'b0, 2);

        // Single-cycle pulse: minimum event pair.
        do_reset();
        cycles(1'b1, 1);
        check("pulse_press", 32'(press), 1);
        cycles(1'b0, 1);
        check("pulse_release", 32'(release_pulse), 1);
        check("pulse_click", 32'(click), 1);
        check("pulse_press_gone", 32'(press), 0);
        cycles(1'b0, 2);
        check("pulse_rel_delay", 32'(rel_cyc - press_cyc), 1);
        check("pulse_rel_count", 32'(n_rel), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
